// File: rtl/gfq_systemizer.sv
// gfq_systemizer: holds an L x K matrix over GF(Q), Q prime, in registers.
// On start it runs Gaussian elimination on the left L x L block. Pivot
// search swaps rows as needed, and the pivot's inverse is found by a
// candidate scan. mode=0 reduces the left block to the identity; mode=1
// stops at upper-unitriangular (row-echelon) form. Columns L..K-1 are
// transformed alongside but are never pivoted.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, mode         begin elimination (IDLE only); mode latched on start
//   busy                high in every state except IDLE
//   done                one-cycle pulse in the DONE state
//   fail, success       sticky status, cleared by the next accepted start
//   wr_en/wr_addr/data_in   word write (IDLE only); each element reduced mod Q
//   rd_en/rd_addr/data_out  word read (IDLE only); data_out registered, holds
//
// Handshake: start, wr_en and rd_en are single-cycle requests sampled on the
// rising edge while IDLE. There is no back-pressure. A request made while
// busy is dropped; it is not queued.
module gfq_systemizer #(
    parameter int Q     = 3,
    parameter int L     = 8,
    parameter int K     = 16,
    parameter int BLOCK = 4,
    parameter int W     = $clog2(Q),
    parameter int AW    = $clog2(L * K / BLOCK)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic               success,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [BLOCK*W-1:0] data_in,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [BLOCK*W-1:0] data_out
);
    localparam int WPR = K / BLOCK;          // words per matrix row
    localparam int RW  = $clog2(L);          // row / column index width (L >= 2)
    localparam logic [W:0]     Q1 = (W + 1)'(Q);
    localparam logic [2*W-1:0] Q2 = (2 * W)'(Q);

    typedef enum logic [2:0] {
        S_IDLE, S_SEARCH, S_SWAP, S_INV, S_NORM, S_ELIM, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_mat [L][K];
    logic               r_mode;
    logic [RW-1:0]      r_col;        // pivot column j
    logic [RW-1:0]      r_row;        // SEARCH: row under test; ELIM: visit count
    logic [W-1:0]       r_inv;        // inverse candidate, frozen once it fits
    logic               r_fail;
    logic               r_success;
    logic [BLOCK*W-1:0] r_data_out;

    logic [W-1:0]  w_cand;
    logic [W-1:0]  w_diag;
    logic          w_inv_ok;
    logic [RW-1:0] w_tgt;
    logic          w_tgt_upd;
    logic [W-1:0]  w_fac;
    logic          w_elim_last;
    logic          w_last_col;
    logic          w_last_row;
    logic [RW-1:0] w_wr_row;
    logic [RW-1:0] w_rd_row;
    int            w_wr_col;
    int            w_rd_col;
    logic          w_wr_ok;
    logic          w_rd_ok;

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % Q2);
    endfunction

    // a - b mod Q; adding Q first keeps the intermediate non-negative.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + Q1 - {1'b0, b};
        return W'(s % Q1);
    endfunction

    function automatic logic [W-1:0] red_mod(input logic [W-1:0] e);
        return W'({1'b0, e} % Q1);
    endfunction

    always_comb begin
        w_cand      = r_mat[r_row][r_col];
        w_diag      = r_mat[r_col][r_col];
        w_inv_ok    = (mul_mod(w_diag, r_inv) == W'(1));
        // ELIM visits rows 0..L-1 with the pivot row skipped: count c maps to
        // row c below the pivot and to row c+1 from the pivot onwards.
        w_tgt       = (r_row < r_col) ? r_row : r_row + RW'(1);
        w_tgt_upd   = !r_mode || (w_tgt > r_col);
        w_fac       = r_mat[w_tgt][r_col];
        w_elim_last = (r_row == RW'(L - 2));
        w_last_col  = (r_col == RW'(L - 1));
        w_last_row  = (r_row == RW'(L - 1));
        w_wr_row    = RW'(int'(wr_addr) / WPR);
        w_wr_col    = (int'(wr_addr) % WPR) * BLOCK;
        w_rd_row    = RW'(int'(rd_addr) / WPR);
        w_rd_col    = (int'(rd_addr) % WPR) * BLOCK;
        w_wr_ok     = (int'(wr_addr) < L * WPR);
        w_rd_ok     = (int'(rd_addr) < L * WPR);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SEARCH;
            S_SEARCH: begin
                if (w_cand != '0)    w_next = (r_row != r_col) ? S_SWAP : S_INV;
                else if (w_last_row) w_next = S_DONE;
            end
            S_SWAP:   w_next = S_INV;
            S_INV:    if (w_inv_ok) w_next = S_NORM;
            S_NORM:   w_next = S_ELIM;
            S_ELIM:   if (w_elim_last) w_next = w_last_col ? S_DONE : S_SEARCH;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        fail     = r_fail;
        success  = r_success;
        data_out = r_data_out;
    end

    // Matrix and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++)
                for (int k = 0; k < K; k++)
                    r_mat[i][k] <= '0;
            r_mode     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_inv      <= '0;
            r_fail     <= 1'b0;
            r_success  <= 1'b0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wr_en && w_wr_ok)
                        for (int i = 0; i < BLOCK; i++)
                            r_mat[w_wr_row][w_wr_col + i] <= red_mod(data_in[i*W +: W]);
                    if (rd_en && w_rd_ok)
                        for (int i = 0; i < BLOCK; i++)
                            r_data_out[i*W +: W] <= r_mat[w_rd_row][w_rd_col + i];
                    if (start) begin
                        r_mode    <= mode;
                        r_fail    <= 1'b0;
                        r_success <= 1'b0;
                        r_col     <= '0;
                        r_row     <= '0;
                    end
                end
                S_SEARCH: begin
                    // r_row is left on the pivot row so SWAP knows which row to move.
                    if (w_cand != '0)    r_inv  <= W'(1);
                    else if (w_last_row) r_fail <= 1'b1;
                    else                 r_row  <= r_row + RW'(1);
                end
                S_SWAP: begin
                    for (int k = 0; k < K; k++) begin
                        r_mat[r_row][k] <= r_mat[r_col][k];
                        r_mat[r_col][k] <= r_mat[r_row][k];
                    end
                    r_inv <= W'(1);
                end
                S_INV: begin
                    if (!w_inv_ok) r_inv <= r_inv + W'(1);
                end
                S_NORM: begin
                    for (int k = 0; k < K; k++)
                        r_mat[r_col][k] <= mul_mod(r_mat[r_col][k], r_inv);
                    r_row <= '0;
                end
                S_ELIM: begin
                    if (w_tgt_upd)
                        for (int k = 0; k < K; k++)
                            r_mat[w_tgt][k] <= sub_mod(r_mat[w_tgt][k], mul_mod(w_fac, r_mat[r_col][k]));
                    if (w_elim_last) begin
                        if (w_last_col) begin
                            r_success <= 1'b1;
                        end else begin
                            r_col <= r_col + RW'(1);
                            r_row <= r_col + RW'(1);
                        end
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gfq_systemizer.sv
// Testbench for gfq_systemizer. A behavioural Gaussian-elimination model over
// GF(Q) on plain int arrays predicts the final matrix, the status flags and
// the cycle in which done rises. Readback words are queued in exp_q and then
// compared with what the design returns.
module tb_gfq_systemizer;
    localparam int Q     = 3;
    localparam int L     = 8;
    localparam int K     = 16;
    localparam int BLOCK = 4;
    localparam int W     = $clog2(Q);
    localparam int AW    = $clog2(L * K / BLOCK);
    localparam int NW    = L * K / BLOCK;
    localparam int WPR   = K / BLOCK;
    localparam int DW    = BLOCK * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mode;
    logic          busy;
    logic          done;
    logic          fail;
    logic          success;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] data_out;

    int            total = 0;
    int            bad   = 0;
    int            ld_m  [L][K];
    int            ref_m [L][K];
    logic [DW-1:0] rd_words [NW];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_w;

    gfq_systemizer #(.Q(Q), .L(L), .K(K), .BLOCK(BLOCK)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .fail(fail), .success(success),
        .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] pack_word(input int a, input bit from_ref);
        logic [DW-1:0] d;
        int r;
        int c;
        r = a / WPR;
        c = (a % WPR) * BLOCK;
        d = '0;
        for (int i = 0; i < BLOCK; i++)
            d[i*W +: W] = W'(from_ref ? ref_m[r][c+i] : ld_m[r][c+i]);
        return d;
    endfunction

    function automatic int get_elem(input int r, input int c);
        logic [DW-1:0] wd;
        wd = rd_words[r * WPR + c / BLOCK];
        return int'(wd[(c % BLOCK) * W +: W]);
    endfunction

    function automatic int count_above();
        int n;
        n = 0;
        for (int r = 0; r < L; r++)
            for (int c = r + 1; c < L; c++)
                if (ref_m[r][c] != 0) n++;
        return n;
    endfunction

    task automatic gen_random();
        for (int r = 0; r < L; r++)
            for (int k = 0; k < K; k++)
                ld_m[r][k] = $urandom_range(0, Q - 1);
    endtask

    // Upper-triangular left block with nonzero diagonal, rows shuffled:
    // always full rank, and the shuffle forces row swaps.
    task automatic gen_fullrank();
        int j;
        int t;
        gen_random();
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                if (c < r)       ld_m[r][c] = 0;
                else if (c == r) ld_m[r][c] = $urandom_range(1, Q - 1);
        for (int i = L - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            for (int k = 0; k < K; k++) begin
                t = ld_m[i][k]; ld_m[i][k] = ld_m[j][k]; ld_m[j][k] = t;
            end
        end
    endtask

    task automatic gen_identity();
        gen_random();
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                ld_m[r][c] = (r == c) ? 1 : 0;
    endtask

    // Reference model: textbook GF(Q) elimination, plus the cycle in which
    // done is expected (cycle 1 = first cycle after start is sampled).
    task automatic model_run(input bit md, output int lat, output bit f, output bit s);
        int p;
        int inv;
        int fac;
        int t;
        lat = 0; f = 0; s = 0;
        for (int j = 0; j < L; j++) begin
            p = -1;
            for (int r = j; r < L && p < 0; r++) begin
                lat++;
                if (ref_m[r][j] != 0) p = r;
            end
            if (p < 0) begin
                f = 1;
                break;
            end
            if (p != j) begin
                lat++;
                for (int k = 0; k < K; k++) begin
                    t = ref_m[p][k]; ref_m[p][k] = ref_m[j][k]; ref_m[j][k] = t;
                end
            end
            inv = 0;
            for (int c = 1; c < Q && inv == 0; c++) begin
                lat++;
                if ((ref_m[j][j] * c) % Q == 1) inv = c;
            end
            lat++;
            for (int k = 0; k < K; k++) ref_m[j][k] = (ref_m[j][k] * inv) % Q;
            lat += L - 1;
            for (int r = 0; r < L; r++) begin
                if (r != j && (md == 0 || r > j)) begin
                    fac = ref_m[r][j];
                    for (int k = 0; k < K; k++)
                        ref_m[r][k] = ((ref_m[r][k] - fac * ref_m[j][k]) % Q + Q) % Q;
                end
            end
        end
        if (f == 0) s = 1;
        lat++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_word(input int a, input logic [DW-1:0] d);
        @(negedge clk); wr_en = 1'b1; wr_addr = AW'(a); data_in = d;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic load_matrix();
        for (int a = 0; a < NW; a++) write_word(a, pack_word(a, 1'b0));
    endtask

    task automatic read_all();
        for (int a = 0; a < NW; a++) begin
            @(negedge clk); rd_en = 1'b1; rd_addr = AW'(a);
            @(negedge clk); rd_en = 1'b0; rd_words[a] = data_out;
        end
    endtask

    task automatic push_expected();
        exp_q.delete();
        for (int a = 0; a < NW; a++) exp_q.push_back(pack_word(a, 1'b1));
    endtask

    // Pulses start, scrambles mode afterwards (it must be latched), and
    // reports the cycle in which done rose (-1 on timeout).
    task automatic run_start(input bit md, output int lat, output bit early_ok, output bit pulse_ok);
        @(negedge clk); start = 1'b1; mode = md;
        @(negedge clk); start = 1'b0; mode = 1'($urandom_range(0, 1));
        early_ok = (busy === 1'b1 && done === 1'b0 && fail === 1'b0 && success === 1'b0);
        lat = 1;
        while (done !== 1'b1 && lat < 5000) begin
            @(negedge clk); lat++;
        end
        if (done !== 1'b1) lat = -1;
        @(negedge clk);
        pulse_ok = (done === 1'b0 && busy === 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (fail !== 1'b0)    begin bad++; $display("FAIL reset_fail got=%b exp=0", fail); end
        total++; if (success !== 1'b0) begin bad++; $display("FAIL reset_success got=%b exp=0", success); end
        total++; if (data_out !== '0)  begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        rst = 1'b0;
        for (int r = 0; r < L; r++) for (int k = 0; k < K; k++) ref_m[r][k] = 0;
        push_expected(); read_all();
        for (int a = 0; a < NW; a++) begin
            exp_w = exp_q.pop_front(); total++;
            if (rd_words[a] !== exp_w) begin bad++; $display("FAIL reset_read a=%0d got=%h exp=%h", a, rd_words[a], exp_w); end
        end
    endtask

    task automatic test_write_read();
        int a;
        logic [DW-1:0] d;
        for (int r = 0; r < L; r++) for (int k = 0; k < K; k++) ld_m[r][k] = 0;
        for (int n = 0; n < 12; n++) begin
            a = $urandom_range(0, NW - 1);
            d = (n == 0) ? '1 : DW'($urandom);
            write_word(a, d);
            for (int i = 0; i < BLOCK; i++)
                ld_m[a / WPR][(a % WPR) * BLOCK + i] = int'(d[i*W +: W]) % Q;
        end
        ref_m = ld_m;
        push_expected(); read_all();
        for (int i = 0; i < NW; i++) begin
            exp_w = exp_q.pop_front(); total++;
            if (rd_words[i] !== exp_w) begin bad++; $display("FAIL wr_reduce_read a=%0d got=%h exp=%h", i, rd_words[i], exp_w); end
        end
        // data_out must hold between reads
        exp_w = rd_words[NW - 1];
        repeat (3) @(negedge clk);
        total++; if (data_out !== exp_w) begin bad++; $display("FAIL read_hold got=%h exp=%h", data_out, exp_w); end
    endtask

    task automatic test_load_run(input string name, input bit md);
        int m_lat; bit m_f; bit m_s;
        int lat; bit early_ok; bit pulse_ok;
        load_matrix();
        ref_m = ld_m;
        model_run(md, m_lat, m_f, m_s);
        run_start(md, lat, early_ok, pulse_ok);
        total++; if (lat != m_lat)       begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, m_lat); end
        total++; if (early_ok !== 1'b1)  begin bad++; $display("FAIL %s_start_state got=%b exp=1", name, early_ok); end
        total++; if (pulse_ok !== 1'b1)  begin bad++; $display("FAIL %s_done_pulse got=%b exp=1", name, pulse_ok); end
        total++; if (fail !== m_f)       begin bad++; $display("FAIL %s_fail got=%b exp=%b", name, fail, m_f); end
        total++; if (success !== m_s)    begin bad++; $display("FAIL %s_success got=%b exp=%b", name, success, m_s); end
        push_expected(); read_all();
        for (int a = 0; a < NW; a++) begin
            exp_w = exp_q.pop_front(); total++;
            if (rd_words[a] !== exp_w) begin bad++; $display("FAIL %s_read a=%0d got=%h exp=%h", name, a, rd_words[a], exp_w); end
        end
    endtask

    task automatic test_identity();
        gen_identity();
        test_load_run("identity", 1'b0);
        total++; if (success !== 1'b1) begin bad++; $display("FAIL identity_81 success=%b exp=1", success); end
    endtask

    task automatic test_zero_col();
        gen_random();
        for (int r = 0; r < L; r++) ld_m[r][0] = 0;
        test_load_run("zero_col", 1'b0);
    endtask

    task automatic test_swap();
        gen_identity();
        ld_m[0][0] = 0; ld_m[0][1] = 2;
        ld_m[1][0] = 2; ld_m[1][1] = 1;
        test_load_run("swap", 1'b0);
    endtask

    task automatic test_mode1();
        bit tri_ok; int above; int e;
        int m_lat; bit m_f; bit m_s;
        for (int n = 0; n < 16; n++) begin
            gen_fullrank();
            ref_m = ld_m;
            model_run(1'b1, m_lat, m_f, m_s);
            if (count_above() > 0) break;
        end
        test_load_run("mode1", 1'b1);
        tri_ok = 1'b1; above = 0;
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++) begin
                e = get_elem(r, c);
                if (c < r && e != 0)  tri_ok = 1'b0;
                if (c == r && e != 1) tri_ok = 1'b0;
                if (c > r && e != 0)  above++;
            end
        total++; if (tri_ok !== 1'b1) begin bad++; $display("FAIL mode1_unitriangular got=%b exp=1", tri_ok); end
        total++; if (above == 0)      begin bad++; $display("FAIL mode1_above_kept got=%0d exp=>0", above); end
    endtask

    task automatic test_busy_ignore();
        int m_lat; bit m_f; bit m_s; int lat;
        logic [DW-1:0] held;
        gen_fullrank();
        load_matrix();
        ref_m = ld_m;
        model_run(1'b0, m_lat, m_f, m_s);
        @(negedge clk); rd_en = 1'b1; rd_addr = AW'(3);
        @(negedge clk); rd_en = 1'b0; held = data_out;
        exp_w = pack_word(3, 1'b0);
        total++; if (held !== exp_w) begin bad++; $display("FAIL idle_read got=%h exp=%h", held, exp_w); end
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0; lat = 1;
        for (int n = 0; n < 6; n++) begin
            wr_en = 1'b1; wr_addr = AW'(n); data_in = DW'($urandom);
            rd_en = 1'b1; rd_addr = AW'(n + 4); start = 1'b1;
            @(negedge clk); lat++;
            total++; if (data_out !== held) begin bad++; $display("FAIL busy_hold n=%0d got=%h exp=%h", n, data_out, held); end
        end
        wr_en = 1'b0; rd_en = 1'b0; start = 1'b0;
        while (done !== 1'b1 && lat < 5000) begin
            @(negedge clk); lat++;
        end
        if (done !== 1'b1) lat = -1;
        total++; if (lat != m_lat)    begin bad++; $display("FAIL busy_latency got=%0d exp=%0d", lat, m_lat); end
        @(negedge clk);
        total++; if (success !== m_s) begin bad++; $display("FAIL busy_success got=%b exp=%b", success, m_s); end
        push_expected(); read_all();
        for (int a = 0; a < NW; a++) begin
            exp_w = exp_q.pop_front(); total++;
            if (rd_words[a] !== exp_w) begin bad++; $display("FAIL busy_read a=%0d got=%h exp=%h", a, rd_words[a], exp_w); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        gen_identity();
        load_matrix();
        @(negedge clk); rd_en = 1'b1; rd_addr = AW'(0);
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0; n = 1;
        // column 3 occupies cycles 31..40; ELIM runs 34..40
        while (n < 36) begin @(negedge clk); n++; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL mid_rst_done got=%b exp=0", done); end
        total++; if (fail !== 1'b0)    begin bad++; $display("FAIL mid_rst_fail got=%b exp=0", fail); end
        total++; if (success !== 1'b0) begin bad++; $display("FAIL mid_rst_success got=%b exp=0", success); end
        total++; if (data_out !== '0)  begin bad++; $display("FAIL mid_rst_data_out got=%h exp=0", data_out); end
        rst = 1'b0;
        for (int r = 0; r < L; r++) for (int k = 0; k < K; k++) ref_m[r][k] = 0;
        push_expected(); read_all();
        for (int a = 0; a < NW; a++) begin
            exp_w = exp_q.pop_front(); total++;
            if (rd_words[a] !== exp_w) begin bad++; $display("FAIL mid_rst_read a=%0d got=%h exp=%h", a, rd_words[a], exp_w); end
        end
        test_identity();
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            gen_random();
            test_load_run("random", 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; data_in = '0;
        test_reset();
        test_write_read();
        test_identity();
        test_zero_col();
        test_swap();
        test_mode1();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
